replica_xchg_sched: RTL and testbench

Sequencer for the replica route RAM array. Per pass, it converts a requested replica-exchange vector into a non-conflicting set of per-replica commands. It issues those commands for one cycle, times the RAM stream plus pipeline drain, then flips the shared read bank and signals completion. It sits between the annealing/exchange decision logic and the bank of per-replica route RAMs.

---
 rtl/replica_xchg_sched.sv | 148 ++++++++++++++
 tb/tb_replica_xchg_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/replica_xchg_sched.sv
// Replica-exchange pass sequencer: masks exchange requests, issues one cycle of per-replica
// route commands, times the RAM stream and pipeline drain, then flips the read bank.
// Optional statistics counters are compiled in with `define XCHG_STAT_EN.
module replica_xchg_sched #(
  parameter int REPLICA_NUM = 32,
  parameter int CITY_NUM    = 30,
  parameter int PIPE_LAT    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [REPLICA_NUM-2:0]   xchg_req,
  output logic                     busy,
  output logic [2*REPLICA_NUM-1:0] command,
  output logic                     rbank,
  output logic                     done,
  output logic [REPLICA_NUM-2:0]   xchg_grant
`ifdef XCHG_STAT_EN
  ,
  input  logic                     stat_clr,
  output logic [31:0]              stat_grant,
  output logic [31:0]              stat_conflict
`endif
);

  localparam int CNT_W = $clog2(CITY_NUM + PIPE_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CITY_NUM + PIPE_LAT - 1);

  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_PREV = 2'd1;
  localparam logic [1:0] CMD_FOLW = 2'd2;
  localparam logic [1:0] CMD_SELF = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_STREAM,
    S_SWAP
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [REPLICA_NUM-2:0] grant_c;
  logic                   carry_c;
  logic                   accept;

  // Each replica lands in at most one pair; a lower index claims its neighbour first.
  function automatic logic [2*REPLICA_NUM-1:0] map_cmd(input logic [REPLICA_NUM-2:0] g);
    logic [REPLICA_NUM:0]       gx;
    logic [2*REPLICA_NUM-1:0]   c;
    gx = {1'b0, g, 1'b0};
    c  = '0;
    for (int r = 0; r < REPLICA_NUM; r++) begin
      if (gx[r+1])
        c[2*r +: 2] = CMD_FOLW;
      else if (gx[r])
        c[2*r +: 2] = CMD_PREV;
      else
        c[2*r +: 2] = CMD_SELF;
    end
    return c;
  endfunction

  always_comb begin
    grant_c = '0;
    carry_c = 1'b0;
    for (int i = 0; i < REPLICA_NUM - 1; i++) begin
      grant_c[i] = xchg_req[i] & ~carry_c;
      carry_c    = xchg_req[i] & ~carry_c;
    end
  end

  assign accept = (state == S_IDLE) && start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      command    <= '0;
      rbank      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      xchg_grant <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done    <= 1'b0;
          command <= {REPLICA_NUM{CMD_NOP}};
          if (start) begin
            xchg_grant <= grant_c;
            command    <= map_cmd(grant_c);
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          command <= {REPLICA_NUM{CMD_NOP}};
          cnt     <= CNT_LOAD;
          state   <= S_STREAM;
        end
        S_STREAM: begin
          if (cnt == '0) begin
            state <= S_SWAP;
            done  <= 1'b1;
            rbank <= ~rbank;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_SWAP: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef XCHG_STAT_EN
  function automatic logic [31:0] popcnt(input logic [REPLICA_NUM-2:0] v);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < REPLICA_NUM - 1; i++) s = s + 32'(v[i]);
    return s;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_grant    <= '0;
      stat_conflict <= '0;
    end else if (stat_clr) begin
      stat_grant    <= '0;
      stat_conflict <= '0;
    end else if (accept) begin
      stat_grant    <= sat_add(stat_grant, popcnt(grant_c));
      stat_conflict <= sat_add(stat_conflict, popcnt(xchg_req & ~grant_c));
    end
  end
`endif

endmodule

// File: tb/tb_replica_xchg_sched.sv
// Randomized bench for replica_xchg_sched against a pass-timeline reference model.
`timescale 1ns/1ps
module tb_replica_xchg_sched;
  localparam int N    = 4;
  localparam int CITY = 30;
  localparam int PIPE = 4;
  localparam int L    = CITY + PIPE;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [N-2:0]   xchg_req = '0;
  logic           busy, rbank, done;
  logic [2*N-1:0] command;
  logic [N-2:0]   xchg_grant;
`ifdef XCHG_STAT_EN
  logic           stat_clr = 1'b0;
  logic [31:0]    stat_grant, stat_conflict;
`endif

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;

  // Reference model: t = cycles since accept (1 = issue, L+2 = swap), -1 when idle.
  int             t = -1;
  logic           m_rbank = 1'b0;
  logic [N-2:0]   m_grant = '0;
  logic [2*N-1:0] m_cmd = '0;
  longint         m_sg = 0;
  longint         m_sc = 0;

  always #5 clk = ~clk;

  replica_xchg_sched #(.REPLICA_NUM(N), .CITY_NUM(CITY), .PIPE_LAT(PIPE)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .xchg_req(xchg_req),
    .busy(busy),
    .command(command),
    .rbank(rbank),
    .done(done),
    .xchg_grant(xchg_grant)
`ifdef XCHG_STAT_EN
    ,
    .stat_clr(stat_clr),
    .stat_grant(stat_grant),
    .stat_conflict(stat_conflict)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pair replicas greedily from the bottom; an already-paired replica cannot pair again.
  function automatic logic [N-2:0] ref_grant(input logic [N-2:0] req);
    bit           paired[N];
    logic [N-2:0] g;
    g = '0;
    for (int i = 0; i < N; i++) paired[i] = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if (req[i] && !paired[i]) begin
        g[i] = 1'b1;
        paired[i] = 1'b1;
        paired[i+1] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [2*N-1:0] ref_cmd(input logic [N-2:0] g);
    int             partner[N];
    logic [2*N-1:0] c;
    for (int r = 0; r < N; r++) partner[r] = r;
    for (int i = 0; i < N - 1; i++) begin
      if (g[i]) begin
        partner[i] = i + 1;
        partner[i+1] = i;
      end
    end
    c = '0;
    for (int r = 0; r < N; r++) begin
      if (partner[r] == r)     c[2*r +: 2] = 2'd3;
      else if (partner[r] > r) c[2*r +: 2] = 2'd2;
      else                     c[2*r +: 2] = 2'd1;
    end
    return c;
  endfunction

  function automatic longint pop(input logic [N-2:0] v);
    longint s = 0;
    for (int i = 0; i < N - 1; i++) if (v[i]) s++;
    return s;
  endfunction

  task automatic model_reset();
    t = -1;
    m_rbank = 1'b0;
    m_grant = '0;
    m_cmd = '0;
    m_sg = 0;
    m_sc = 0;
  endtask

  task automatic model_update(input bit s, input logic [N-2:0] req, input bit clr);
    bit acc;
    acc = 1'b0;
    if (t < 0) begin
      if (s) begin
        acc = 1'b1;
        m_grant = ref_grant(req);
        m_cmd = ref_cmd(m_grant);
        t = 1;
      end
    end else if (t == L + 2) begin
      t = -1;
    end else begin
      t++;
      if (t == L + 2) m_rbank = ~m_rbank;
    end
    if (clr) begin
      m_sg = 0;
      m_sc = 0;
    end else if (acc) begin
      m_sg = m_sg + pop(m_grant);
      m_sc = m_sc + pop(req & ~m_grant);
      if (m_sg > 64'hFFFF_FFFF) m_sg = 64'hFFFF_FFFF;
      if (m_sc > 64'hFFFF_FFFF) m_sc = 64'hFFFF_FFFF;
    end
  endtask

  task automatic check_outputs();
    chk("busy", 64'(busy), 64'(t >= 1 && t <= L + 1));
    chk("done", 64'(done), 64'(t == L + 2));
    chk("rbank", 64'(rbank), 64'(m_rbank));
    chk("command", 64'(command), (t == 1) ? 64'(m_cmd) : 64'(0));
    chk("xchg_grant", 64'(xchg_grant), 64'(m_grant));
`ifdef XCHG_STAT_EN
    chk("stat_grant", 64'(stat_grant), 64'(m_sg));
    chk("stat_conflict", 64'(stat_conflict), 64'(m_sc));
`endif
    if (done) n_done++;
  endtask

  task automatic step(input bit s, input logic [N-2:0] req, input bit clr);
    start = s;
    xchg_req = req;
`ifdef XCHG_STAT_EN
    stat_clr = clr;
`endif
    @(posedge clk);
    if (!reset) model_reset();
    else model_update(s, req, clr);
    #1;
    check_outputs();
  endtask

  task automatic run_to_idle();
    for (int k = 0; k < 200 && t != -1; k++) step(1'b0, (N-1)'($urandom), 1'b0);
    chk("reach_idle", 64'(t), 64'(-1) & 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  task automatic async_reset_pulse();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("rst_cmd", 64'(command), 64'(0));
    chk("rst_rbank", 64'(rbank), 64'(0));
    step(1'b1, (N-1)'($urandom), 1'b0);
    step(1'b1, (N-1)'($urandom), 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    int cur;
    int nd1, nd2;

    // Reset held, then released with no start for 100 cycles.
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("reset_cmd", 64'(command), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    reset = 1'b1;
    for (int k = 0; k < 100; k++) step(1'b0, (N-1)'($urandom), 1'b0);

    // Pass with no exchanges: everyone SELF.
    step(1'b1, 3'b000, 1'b0);
    cur = 1;
    chk("issue_self", 64'(command), 64'hFF);
    while (cur < 37) begin
      step(1'b0, (N-1)'($urandom), 1'b0);
      cur++;
      if (cur == 36) begin
        chk("p1_done36", 64'(done), 64'(1));
        chk("p1_rbank36", 64'(rbank), 64'(1));
      end
      if (cur == 37) chk("p1_busy37", 64'(busy), 64'(0));
    end

    // Full request vector with ignored and back-to-back starts.
    step(1'b1, 3'b111, 1'b0);
    cur = 1;
    nd1 = 0;
    nd2 = 0;
    chk("issue_xchg", 64'(command), 64'h66);
    chk("grant_xchg", 64'(xchg_grant), 64'b101);
    while (cur < 73) begin
      step(cur == 5 || cur == 36 || cur == 37, (N-1)'($urandom), 1'b0);
      cur++;
      if (done && cur <= 36) nd1++;
      if (done && cur > 36) nd2++;
      if (cur == 36) chk("p2_rbank36", 64'(rbank), 64'(0));
      if (cur == 73) begin
        chk("p3_done73", 64'(done), 64'(1));
        chk("p3_rbank73", 64'(rbank), 64'(1));
      end
    end
    chk("p2_ndone", 64'(nd1), 64'(1));
    chk("p3_ndone", 64'(nd2), 64'(1));
    run_to_idle();

    // Abort mid-pass by reset, then a normal pass.
    step(1'b1, (N-1)'($urandom), 1'b0);
    cur = 1;
    while (cur < 20) begin
      step(1'b0, (N-1)'($urandom), 1'b0);
      cur++;
    end
    nd1 = n_done;
    async_reset_pulse();
    chk("abort_no_done", 64'(n_done), 64'(nd1));
    step(1'b1, 3'b111, 1'b0);
    run_to_idle();
    step(1'b1, 3'b010, 1'b0);
    run_to_idle();
`ifdef XCHG_STAT_EN
    chk("stat_grant_3", 64'(stat_grant), 64'(3));
    chk("stat_conflict_1", 64'(stat_conflict), 64'(1));
    step(1'b1, 3'b111, 1'b1);
    chk("stat_clr_grant", 64'(stat_grant), 64'(0));
    chk("stat_clr_conflict", 64'(stat_conflict), 64'(0));
`else
    step(1'b1, 3'b111, 1'b0);
`endif
    run_to_idle();

    // Random traffic with occasional asynchronous resets.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset_pulse();
      end else begin
        step($urandom_range(0, 7) == 0, (N-1)'($urandom), $urandom_range(0, 49) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
